// File: rtl/dis_issue_receiver.sv
// Generic issue queue on the receiving side of dispatch->issue. Holds up to
// DEPTH uops, tracks operand readiness from the wakeup bus, picks the oldest
// ready entry for one execution port, and flushes entries younger than a
// backend redirect. Relative age lives in a DEPTH x DEPTH matrix.
module dis_issue_receiver #(
  parameter int DEPTH      = 8,
  parameter int IN_WIDTH   = 2,
  parameter int DATA_WIDTH = 64,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 6,
  parameter int WAKE_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_WIDTH-1:0]            dis_en,
  input  logic [IN_WIDTH*DATA_WIDTH-1:0] dis_data,
  input  logic [IN_WIDTH-1:0]            dis_rs1v,
  input  logic [IN_WIDTH-1:0]            dis_rs2v,
  input  logic [IN_WIDTH*PREG_WIDTH-1:0] dis_rs1,
  input  logic [IN_WIDTH*PREG_WIDTH-1:0] dis_rs2,
  input  logic [IN_WIDTH*(ROB_WIDTH+1)-1:0] dis_robIdx,
  output logic                           full,
  input  logic [WAKE_WIDTH-1:0]          wake_en,
  input  logic [WAKE_WIDTH*PREG_WIDTH-1:0] wake_preg,
  input  logic                           redirect,
  input  logic [ROB_WIDTH:0]             redirectIdx,
  output logic                           issue_en,
  input  logic                           issue_ready,
  output logic [DATA_WIDTH-1:0]          issue_data,
  output logic [PREG_WIDTH-1:0]          issue_rs1,
  output logic [PREG_WIDTH-1:0]          issue_rs2,
  output logic [ROB_WIDTH:0]             issue_robIdx
);
  localparam int RW = ROB_WIDTH + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]                 valid, rs1v, rs2v, valid_nxt;
  logic [DEPTH-1:0][PREG_WIDTH-1:0] rs1, rs2;
  logic [DEPTH-1:0][RW-1:0]         rob;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data;
  logic [DEPTH-1:0][DEPTH-1:0]      age, age_nxt;   // age[i][j]: i older than j
  logic [CW-1:0]                    count;
  logic [DEPTH-1:0]                 ready, sel, free;
  logic [IN_WIDTH-1:0]              acc;
  logic [IN_WIDTH-1:0][IW-1:0]      alloc_idx;
  logic                             deq;
  int                               n_acc, n_flush, count_calc;

  function automatic logic woke(input logic [PREG_WIDTH-1:0] tag,
                                input logic [WAKE_WIDTH-1:0] en,
                                input logic [WAKE_WIDTH*PREG_WIDTH-1:0] preg);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_WIDTH; w++)
      if (en[w] && preg[w*PREG_WIDTH +: PREG_WIDTH] == tag) hit = 1'b1;
    return hit;
  endfunction

  // a is strictly younger than b, accounting for the ROB wrap bit
  function automatic logic younger(input logic [RW-1:0] a, input logic [RW-1:0] b);
    if (a[RW-1] == b[RW-1]) return a[RW-2:0] > b[RW-2:0];
    else                    return a[RW-2:0] < b[RW-2:0];
  endfunction

  assign full = count > CW'(DEPTH - IN_WIDTH);

  // lowest free slot to lowest asserted lane; slots freed this cycle stay busy
  always_comb begin
    free  = ~valid;
    acc   = '0;
    n_acc = 0;
    for (int l = 0; l < IN_WIDTH; l++) begin
      alloc_idx[l] = '0;
      if (dis_en[l] && !redirect)
        for (int i = 0; i < DEPTH; i++)
          if (free[i] && !acc[l]) begin
            acc[l]       = 1'b1;
            alloc_idx[l] = IW'(i);
            free[i]      = 1'b0;
            n_acc        = n_acc + 1;
          end
    end
  end

  // oldest-ready select: an entry wins if no other ready entry is older
  always_comb begin
    ready = valid & rs1v & rs2v;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (ready[j] && age[j][i]) sel[i] = 1'b0;
    end
  end

  assign issue_en = (|ready) & ~redirect;
  assign deq      = issue_en & issue_ready;

  // issue payload mux; zero whenever nothing issues
  always_comb begin
    issue_data   = '0;
    issue_rs1    = '0;
    issue_rs2    = '0;
    issue_robIdx = '0;
    if (issue_en)
      for (int i = 0; i < DEPTH; i++)
        if (sel[i]) begin
          issue_data   = issue_data   | data[i];
          issue_rs1    = issue_rs1    | rs1[i];
          issue_rs2    = issue_rs2    | rs2[i];
          issue_robIdx = issue_robIdx | rob[i];
        end
  end

  // next valid set, occupancy and age matrix
  always_comb begin
    valid_nxt = valid;
    n_flush   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (redirect && valid[i] && younger(rob[i], redirectIdx)) begin
        valid_nxt[i] = 1'b0;
        n_flush      = n_flush + 1;
      end
      if (deq && sel[i]) valid_nxt[i] = 1'b0;
    end
    age_nxt = age;
    // lanes in order: each new entry is younger than everything before it,
    // and a later lane's row clear removes an earlier lane's column bit
    for (int l = 0; l < IN_WIDTH; l++)
      if (acc[l]) begin
        valid_nxt[alloc_idx[l]] = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          age_nxt[alloc_idx[l]][j] = 1'b0;
          age_nxt[j][alloc_idx[l]] = (j != int'(alloc_idx[l]));
        end
      end
    count_calc = int'(count) + n_acc - int'(deq) - n_flush;
  end

  // entry state: wakeup of resident entries, then enqueue with same-cycle bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      rs1v  <= '0;
      rs2v  <= '0;
      rs1   <= '0;
      rs2   <= '0;
      rob   <= '0;
      data  <= '0;
      age   <= '0;
      count <= '0;
    end else begin
      valid <= valid_nxt;
      age   <= age_nxt;
      count <= CW'(count_calc);
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !rs1v[i] && woke(rs1[i], wake_en, wake_preg)) rs1v[i] <= 1'b1;
        if (valid[i] && !rs2v[i] && woke(rs2[i], wake_en, wake_preg)) rs2v[i] <= 1'b1;
      end
      for (int l = 0; l < IN_WIDTH; l++)
        if (acc[l]) begin
          data[alloc_idx[l]] <= dis_data[l*DATA_WIDTH +: DATA_WIDTH];
          rs1[alloc_idx[l]]  <= dis_rs1[l*PREG_WIDTH +: PREG_WIDTH];
          rs2[alloc_idx[l]]  <= dis_rs2[l*PREG_WIDTH +: PREG_WIDTH];
          rob[alloc_idx[l]]  <= dis_robIdx[l*RW +: RW];
          rs1v[alloc_idx[l]] <= dis_rs1v[l] |
                                woke(dis_rs1[l*PREG_WIDTH +: PREG_WIDTH], wake_en, wake_preg);
          rs2v[alloc_idx[l]] <= dis_rs2v[l] |
                                woke(dis_rs2[l*PREG_WIDTH +: PREG_WIDTH], wake_en, wake_preg);
        end
    end
  end

  // protocol and occupancy checks
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (redirect || !(|dis_en && full));
      assert (count_calc >= 0 && count_calc <= DEPTH);
    end
  end
endmodule
